// File: rtl/register_file_param.sv
// Parameterised multi-port register file with a pending-bit scoreboard,
// same-cycle write forwarding and a one-register-per-cycle clear sweep.
module register_file_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] addr_r1_i,
  input  logic [ADDR_WIDTH-1:0] addr_r2_i,
  input  logic [ADDR_WIDTH-1:0] addr_w_i,
  input  logic [DATA_WIDTH-1:0] data_w_i,
  input  logic                  rsv_i,
  input  logic [ADDR_WIDTH-1:0] addr_rsv_i,
  input  logic                  clr_i,
  output logic [DATA_WIDTH-1:0] data_r1_o,
  output logic [DATA_WIDTH-1:0] data_r2_o,
  output logic                  pend_r1_o,
  output logic                  pend_r2_o,
  output logic                  busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

  state_e                  state_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]        pend_q;
  logic [DATA_WIDTH-1:0]   data_r1_q;
  logic [DATA_WIDTH-1:0]   data_r2_q;
  logic                    pend_r1_q;
  logic                    pend_r2_q;

  logic                    we_c;
  logic                    rsv_c;
  logic [DATA_WIDTH-1:0]   data_r1_d;
  logic [DATA_WIDTH-1:0]   data_r2_d;
  logic                    pend_r1_d;
  logic                    pend_r2_d;

  // Accepted write / reserve: blocked during a sweep and at the hardwired zero register.
  assign we_c  = write_i && !busy_q && !(ZERO_REG && (addr_w_i == '0));
  assign rsv_c = rsv_i   && !busy_q && !(ZERO_REG && (addr_rsv_i == '0));

  // Read port 1 next value: zero register overrides forwarding, which overrides storage.
  always_comb begin
    data_r1_d = regs_q[addr_r1_i];
    pend_r1_d = pend_q[addr_r1_i];
    if (BYPASS && we_c && (addr_r1_i == addr_w_i)) begin
      data_r1_d = data_w_i;
      pend_r1_d = 1'b0;
    end
    if (ZERO_REG && (addr_r1_i == '0)) begin
      data_r1_d = '0;
      pend_r1_d = 1'b0;
    end
  end

  // Read port 2 next value, same priority as port 1.
  always_comb begin
    data_r2_d = regs_q[addr_r2_i];
    pend_r2_d = pend_q[addr_r2_i];
    if (BYPASS && we_c && (addr_r2_i == addr_w_i)) begin
      data_r2_d = data_w_i;
      pend_r2_d = 1'b0;
    end
    if (ZERO_REG && (addr_r2_i == '0)) begin
      data_r2_d = '0;
      pend_r2_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      idx_q     <= '0;
      pend_q    <= '0;
      data_r1_q <= '0;
      data_r2_q <= '0;
      pend_r1_q <= 1'b0;
      pend_r2_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // Clear sequencer: one register per cycle, index wraps back to 0 on exit.
      case (state_q)
        IDLE: begin
          if (clr_i) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            idx_q   <= '0;
          end
        end
        SWEEP: begin
          regs_q[idx_q] <= '0;
          pend_q[idx_q] <= 1'b0;
          idx_q         <= idx_q + ADDR_WIDTH'(1);
          if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (we_c) begin
        regs_q[addr_w_i] <= data_w_i;
        pend_q[addr_w_i] <= 1'b0;
      end
      // Applied after the write clear so a same-cycle reserve wins.
      if (rsv_c) begin
        pend_q[addr_rsv_i] <= 1'b1;
      end

      if (read_i && !busy_q) begin
        data_r1_q <= data_r1_d;
        data_r2_q <= data_r2_d;
        pend_r1_q <= pend_r1_d;
        pend_r2_q <= pend_r2_d;
      end
    end
  end

  assign data_r1_o = data_r1_q;
  assign data_r2_o = data_r2_q;
  assign pend_r1_o = pend_r1_q;
  assign pend_r2_o = pend_r2_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: forwarding and non-forwarding instances share
// stimulus and are checked against an array-based reference model.
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read, write, rsv, clr;
  logic [4:0]  addr_r1, addr_r2, addr_w, addr_rsv;
  logic [31:0] data_w;

  logic [31:0] d1 [2];
  logic [31:0] d2 [2];
  logic        p1 [2];
  logic        p2 [2];
  logic        bz [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state; index 0 models BYPASS=1, index 1 models BYPASS=0.
  logic [31:0] m_mem  [32];
  logic        m_pend [32];
  int          m_left;
  int          m_idx;
  logic [31:0] e_d1 [2];
  logic [31:0] e_d2 [2];
  logic        e_p1 [2];
  logic        e_p2 [2];

  always #5 clk = ~clk;

  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .read_i(read), .write_i(write),
    .addr_r1_i(addr_r1), .addr_r2_i(addr_r2), .addr_w_i(addr_w), .data_w_i(data_w),
    .rsv_i(rsv), .addr_rsv_i(addr_rsv), .clr_i(clr),
    .data_r1_o(d1[0]), .data_r2_o(d2[0]), .pend_r1_o(p1[0]), .pend_r2_o(p2[0]), .busy_o(bz[0])
  );

  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n), .read_i(read), .write_i(write),
    .addr_r1_i(addr_r1), .addr_r2_i(addr_r2), .addr_w_i(addr_w), .data_w_i(data_w),
    .rsv_i(rsv), .addr_rsv_i(addr_rsv), .clr_i(clr),
    .data_r1_o(d1[1]), .data_r2_o(d2[1]), .pend_r1_o(p1[1]), .pend_r2_o(p2[1]), .busy_o(bz[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic void mread(input logic [4:0] a, input bit fwd,
                                output logic [31:0] d, output logic p);
    if (a == 5'd0) begin
      d = '0; p = 1'b0;
    end else if (fwd && write && (a == addr_w)) begin
      d = data_w; p = 1'b0;
    end else begin
      d = m_mem[a]; p = m_pend[a];
    end
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit busy_now;
    busy_now = (m_left > 0);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = '0; m_pend[i] = 1'b0;
      end
      m_left = 0; m_idx = 0;
      for (int v = 0; v < 2; v++) begin
        e_d1[v] = '0; e_d2[v] = '0; e_p1[v] = 1'b0; e_p2[v] = 1'b0;
      end
    end else begin
      if (read && !busy_now) begin
        for (int v = 0; v < 2; v++) begin
          mread(addr_r1, (v == 0), e_d1[v], e_p1[v]);
          mread(addr_r2, (v == 0), e_d2[v], e_p2[v]);
        end
      end
      if (busy_now) begin
        m_mem[m_idx] = '0; m_pend[m_idx] = 1'b0;
        m_idx++; m_left--;
      end else begin
        if (write && addr_w != 5'd0) begin
          m_mem[addr_w] = data_w; m_pend[addr_w] = 1'b0;
        end
        if (rsv && addr_rsv != 5'd0) m_pend[addr_rsv] = 1'b1;
        if (clr) begin
          m_left = 32; m_idx = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int v = 0; v < 2; v++) begin
      chk($sformatf("i%0d_data_r1", v), d1[v], e_d1[v]);
      chk($sformatf("i%0d_data_r2", v), d2[v], e_d2[v]);
      chk($sformatf("i%0d_pend_r1", v), 32'(p1[v]), 32'(e_p1[v]));
      chk($sformatf("i%0d_pend_r2", v), 32'(p2[v]), 32'(e_p2[v]));
      chk($sformatf("i%0d_busy", v), 32'(bz[v]), 32'(m_left > 0));
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    read = 0; write = 0; rsv = 0; clr = 0;
    addr_r1 = '0; addr_r2 = '0; addr_w = '0; addr_rsv = '0; data_w = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    idle_inputs(); write = 1; addr_w = a; data_w = d;
    cycle();
  endtask

  task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
    idle_inputs(); read = 1; addr_r1 = a1; addr_r2 = a2;
    cycle();
  endtask

  initial begin
    int cnt;
    idle_inputs();
    rst_n = 0;
    m_left = 0; m_idx = 0;
    cycle();
    cycle();
    rst_n = 1;
    chk("reset_busy", 32'(bz[0]), 32'd0);
    chk("reset_data_r1", d1[0], 32'd0);

    // Write then read back.
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd0);
    chk("rd_r5", d1[0], 32'hDEADBEEF);

    // Same-cycle write and read of r7.
    do_write(5'd7, 32'hAAAA5555);
    idle_inputs(); write = 1; addr_w = 5'd7; data_w = 32'h12345678; read = 1; addr_r2 = 5'd7;
    cycle();
    chk("fwd_r7_bypass", d2[0], 32'h12345678);
    chk("fwd_r7_nobypass", d2[1], 32'hAAAA5555);

    // Register 0 is hardwired to zero.
    do_write(5'd0, 32'hFFFFFFFF);
    do_read(5'd0, 5'd0);
    chk("rd_r0", d1[0], 32'h0);

    // Scoreboard reserve/release.
    idle_inputs(); rsv = 1; addr_rsv = 5'd3; cycle();
    do_read(5'd3, 5'd0);
    chk("pend_r3_set", 32'(p1[0]), 32'd1);
    do_write(5'd3, 32'h33);
    do_read(5'd3, 5'd0);
    chk("pend_r3_clr", 32'(p1[0]), 32'd0);
    idle_inputs(); rsv = 1; addr_rsv = 5'd3; write = 1; addr_w = 5'd3; data_w = 32'h44; cycle();
    do_read(5'd3, 5'd3);
    chk("pend_r3_rsv_wins", 32'(p1[0]), 32'd1);
    chk("data_r3_after", d2[1], 32'h44);

    // Randomized traffic with occasional clear and reset.
    for (int k = 0; k < 400; k++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      read     = $urandom_range(0, 1);
      write    = $urandom_range(0, 1);
      rsv      = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 39) == 0);
      addr_r1  = 5'($urandom_range(0, 7));
      addr_r2  = 5'($urandom_range(0, 31));
      addr_w   = 5'($urandom_range(0, 7));
      addr_rsv = 5'($urandom_range(0, 7));
      data_w   = $urandom;
      cycle();
    end
    rst_n = 1;
    idle_inputs();
    for (int k = 0; k < 34; k++) cycle();

    // Fill everything, clear, and count busy cycles; CLR during busy is ignored.
    for (int a = 0; a < 32; a++) do_write(5'(a), $urandom | 32'h1);
    idle_inputs(); clr = 1; cycle(); clr = 0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bz[0] === 1'b1) cnt++;
      clr = (k == 5 || k == 20);
      cycle();
      clr = 0;
    end
    chk("busy_cycles", 32'(cnt), 32'd32);
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a), 5'(31 - a));
      chk("post_clr_zero", d1[0] | d2[1], 32'd0);
    end

    // Reset in the middle of a sweep.
    for (int a = 1; a < 32; a++) do_write(5'(a), 32'hC0DE0000 | 32'(a));
    idle_inputs(); rsv = 1; addr_rsv = 5'd9; cycle();
    do_read(5'd9, 5'd4);
    idle_inputs(); clr = 1; cycle(); clr = 0;
    for (int k = 0; k < 10; k++) cycle();
    rst_n = 0; cycle(); rst_n = 1;
    chk("rst_abort_busy", 32'(bz[0]), 32'd0);
    chk("rst_abort_data", d1[0] | d2[0], 32'd0);
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a), 5'(a));
      chk("post_rst_zero", d1[0], 32'd0);
      chk("post_rst_pend", 32'(p2[0]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
